// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one fetch or data transaction at a time to a single fixed-latency memory.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic own_q, own_d;
  logic mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic gnt_data;
`ifdef MEMARB_RR_EN
  logic last_q, last_d;
  assign gnt_data = d_req & (~if_req | ~last_q);
`else
  assign gnt_data = d_req;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_d       = own_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
`ifdef MEMARB_RR_EN
    last_d      = last_q;
`endif
    if (state_q == IDLE && (if_req || d_req)) begin
      state_d     = BUSY;
      own_d       = gnt_data;
      cnt_d       = 4'(MEM_LAT);
      mem_en_d    = 1'b1;
      mem_wr_d    = gnt_data & d_wr;
      mem_addr_d  = gnt_data ? d_addr : if_addr;
      mem_wdata_d = gnt_data ? d_wdata : '0;
`ifdef MEMARB_RR_EN
      last_d      = gnt_data;
`endif
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d    = DONE;
        if_rdata_d = own_q ? if_rdata_q : mem_rdata;
        d_rdata_d  = (own_q && !mem_wr_q) ? mem_rdata : d_rdata_q;
        if_ready_d = ~own_q;
        d_ready_d  = own_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
`ifdef MEMARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
`ifdef MEMARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_d   = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard for the arbiter at MEM_LAT=4, and a MEM_LAT=1 instance.
module tb_mem_arbiter;
  localparam int LAT = 4;
  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] wdata;} iss_t;
  typedef struct {logic d; logic wr; logic [15:0] addr; logic [15:0] wdata;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ready, d_ready, mem_en, mem_wr, stall_if, stall_d;
  logic if_req1 = 1'b0, d_req1 = 1'b0, d_wr1 = 1'b0;
  logic [15:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic if_ready1, d_ready1, mem_en1, mem_wr1, stall_if1, stall_d1;
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_d(stall_d));
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .stall_if(stall_if1), .stall_d(stall_d1));
  // Memory macro model: read data is valid only in the LAT-th cycle of a transaction.
  logic [3:0] age;
  logic [15:0] wval [256];
  logic [255:0] wvld = '0;
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5C3 : (a * 16'h0101) ^ 16'h3C96;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) age <= '0;
    else begin
      age <= mem_en ? 4'd2 : (age != 4'd0 && age != 4'hF) ? age + 4'd1 : age;
      if (mem_en && mem_wr) begin
        wval[mem_addr[7:0]] <= mem_wdata;
        wvld[mem_addr[7:0]] <= 1'b1;
      end
    end
  end
  always_comb begin
    mem_rdata = 16'hDEAD;
    if ((mem_en ? 4'd1 : age) == 4'(LAT))
      mem_rdata = wvld[mem_addr[7:0]] ? wval[mem_addr[7:0]] : init_val(mem_addr);
  end
  assign mem_rdata1 = mem_en1 ? (mem_addr1 ^ 16'h6B6B) : 16'hDEAD;
  int n_chk = 0, n_fail = 0, cyc = 0, if_cyc = 0, d_cyc = 0, n_dr = 0, nd = 0;
  logic if_seen = 1'b0, d_seen = 1'b0;
  logic ord[$];
  iss_t iss_q[$];
  logic [15:0] if_q[$], d_q[$];
  logic [15:0] exp_d_last = '0;
  logic [15:0] rval [256];
  logic [255:0] rvld = '0;
  vec_t tv [10];
  logic exp_ord [4];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return rvld[a[7:0]] ? rval[a[7:0]] : init_val(a);
  endfunction
  task automatic mon();
    iss_t e;
    if_seen = 1'b0;
    d_seen = 1'b0;
    chk("stall_if", stall_if, if_req & ~if_ready);
    chk("stall_d", stall_d, d_req & ~d_ready);
    if (mem_en && iss_q.size() == 0) chk("unexpected_issue", mem_en, 0);
    else if (mem_en) begin
      e = iss_q.pop_front();
      chk("issue_wr", mem_wr, e.wr);
      chk("issue_addr", mem_addr, e.addr);
      if (e.wr) chk("issue_wdata", mem_wdata, e.wdata);
    end
    if (if_ready) begin
      if_seen = 1'b1;
      if_cyc = cyc;
      ord.push_back(1'b0);
      if (if_q.size() == 0) chk("unexpected_if_ready", if_ready, 0);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (d_ready) begin
      d_seen = 1'b1;
      d_cyc = cyc;
      n_dr++;
      ord.push_back(1'b1);
      if (d_q.size() == 0) chk("unexpected_d_ready", d_ready, 0);
      else chk("d_rdata", d_rdata, d_q.pop_front());
    end
  endtask
  task automatic nc();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic smp();
    @(negedge clk);
    mon();
  endtask
  task automatic push_exp(input logic d, input logic wr, input logic [15:0] a, input logic [15:0] w);
    iss_q.push_back('{wr: d & wr, addr: a, wdata: w});
    if (!d) if_q.push_back(ref_rd(a));
    else if (wr) begin
      d_q.push_back(exp_d_last);
      rval[a[7:0]] = w;
      rvld[a[7:0]] = 1'b1;
    end else begin
      exp_d_last = ref_rd(a);
      d_q.push_back(exp_d_last);
    end
  endtask
  task automatic wait_rdy(input logic d);
    logic got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      nc();
      smp();
      got = d ? d_seen : if_seen;
    end
    if (!got) chk("ready_timeout", d ? d_ready : if_ready, 1);
  endtask
  task automatic run_tv(input int lo, input int hi);
    int prev = 0;
    for (int i = lo; i <= hi; i++) begin
      nc();
      if_req = !tv[i].d;
      d_req = tv[i].d;
      if (tv[i].d) begin
        d_wr = tv[i].wr;
        d_addr = tv[i].addr;
        d_wdata = tv[i].wdata;
      end else if_addr = tv[i].addr;
      push_exp(tv[i].d, tv[i].wr, tv[i].addr, tv[i].wdata);
      smp();
      nc();
      d_wr = ~d_wr;
      d_addr = ~d_addr;
      d_wdata = ~d_wdata;
      if_addr = ~if_addr;
      smp();
      wait_rdy(tv[i].d);
      if (i > lo) chk("throughput", (tv[i].d ? d_cyc : if_cyc) - prev, LAT + 2);
      prev = tv[i].d ? d_cyc : if_cyc;
    end
    nc();
    if_req = 1'b0;
    d_req = 1'b0;
    smp();
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"}, {mem_en, mem_wr, if_ready, d_ready}, 0);
    chk({tag, "_addr_wdata"}, {mem_addr, mem_wdata}, 0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 0);
  endtask
  task automatic do_reset();
    nc();
    rst = 1'b1;
    smp();
    nc();
    rst = 1'b0;
    exp_d_last = '0;
    smp();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0] = '{1'b0, 1'b0, 16'h0011, 16'h0000};
    tv[1] = '{1'b1, 1'b1, 16'h0100, 16'hBEEF};
    tv[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000};
    tv[3] = '{1'b0, 1'b0, 16'h0100, 16'h0000};
    tv[4] = '{1'b1, 1'b1, 16'h0020, 16'h1357};
    tv[5] = '{1'b1, 1'b0, 16'h0030, 16'h0000};
    tv[6] = '{1'b1, 1'b1, 16'h0030, 16'hFFFF};
    tv[7] = '{1'b0, 1'b0, 16'h0030, 16'h0000};
    tv[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000};
    tv[9] = '{1'b1, 1'b0, 16'h0100, 16'h0000};
    smp();
    smp();
    rst_chk("reset");
    chk("reset_stall", {stall_if, stall_d}, 0);
    chk("reset_dut1", {mem_en1, mem_wr1, mem_addr1, mem_wdata1, if_ready1, d_ready1}, 0);
    chk("reset_dut1_rdata", {if_rdata1, d_rdata1, stall_if1, stall_d1}, 0);
    nc();
    rst = 1'b0;
    smp();
    // Single fetch, cycle-exact
    nc();
    if_req = 1'b1;
    if_addr = 16'h0010;
    push_exp(1'b0, 1'b0, 16'h0010, 16'h0000);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) nc();
      if (k == 6) if_req = 1'b0;
      smp();
      chk("fetch_mem_en", mem_en, k == 1);
      chk("fetch_if_ready", if_ready, k == 5);
      chk("fetch_stall_if", stall_if, k <= 4);
    end
    run_tv(0, 8);
    do_reset();
    // Simultaneous requests from IDLE
    nc();
    if_req = 1'b1;
    if_addr = 16'h0040;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0050;
    push_exp(1'b1, 1'b0, 16'h0050, 16'h0000);
    push_exp(1'b0, 1'b0, 16'h0040, 16'h0000);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) nc();
      if (k == 6) d_req = 1'b0;
      if (k == 12) if_req = 1'b0;
      smp();
      chk("cont_d_ready", d_ready, k == 5);
      chk("cont_if_ready", if_ready, k == 11);
      chk("cont_mem_en", mem_en, k == 1 || k == 7);
      chk("cont_stall_if", stall_if, k <= 10);
    end
    // Both ports held high for four transactions
`ifdef MEMARB_RR_EN
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      nd += int'(exp_ord[i]);
      push_exp(exp_ord[i], 1'b0, exp_ord[i] ? 16'h0070 : 16'h0060, 16'h0000);
    end
    ord.delete();
    n_dr = 0;
    nc();
    if_req = 1'b1;
    if_addr = 16'h0060;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0070;
    smp();
    for (int i = 0; i < 80 && ord.size() < 4; i++) begin
      nc();
      if (n_dr == nd) d_req = 1'b0;
      smp();
    end
    chk("held_count", ord.size(), 4);
    for (int i = 0; i < ord.size() && i < 4; i++) chk("grant_order", ord[i], exp_ord[i]);
    nc();
    if_req = 1'b0;
    d_req = 1'b0;
    smp();
    // Reset during a load
    nc();
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0100;
    push_exp(1'b1, 1'b0, 16'h0100, 16'h0000);
    smp();
    nc();
    smp();
    nc();
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    rst_chk("rst_mid");
    d_q.delete();
    exp_d_last = '0;
    smp();
    nc();
    rst = 1'b0;
    smp();
    n_dr = 0;
    for (int i = 0; i < 8; i++) begin
      nc();
      smp();
    end
    chk("no_ready_after_rst", n_dr, 0);
    run_tv(9, 9);
    chk("scoreboard_drained", iss_q.size() + if_q.size() + d_q.size(), 0);
    // MEM_LAT=1 instance: back-to-back loads
    nc();
    d_req1 = 1'b1;
    d_addr1 = 16'h0077;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) nc();
      if (k == 3) d_addr1 = 16'h0078;
      if (k == 4) d_req1 = 1'b0;
      smp();
      chk("lat1_mem_en", mem_en1, k == 1 || k == 4);
      chk("lat1_d_ready", d_ready1, k == 2 || k == 5);
      if (k == 1 || k == 4) chk("lat1_mem_addr", mem_addr1, k == 1 ? 16'h0077 : 16'h0078);
      if (k == 2 || k == 5) chk("lat1_d_rdata", d_rdata1, (k == 2 ? 16'h0077 : 16'h0078) ^ 16'h6B6B);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data port (LW/SW) of the 16-bit processor. It sits between the fetch/memory stages and the memory macro, grants one transaction at a time, and drives the stall signals the pipeline uses while a port waits. The opcode decoder's MemRead/MemWrite outputs feed the data-port request.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, memory access latency in cycles, legal range 1..15
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request (MemRead | MemWrite)
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready
- d_ready  out  1  one-cycle data completion pulse
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address, held for the whole transaction
- mem_wdata  out  DATA_W  memory write data, held for the whole transaction
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  if_req high and if_ready low
- stall_d  out  1  d_req high and d_ready low

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request is high, grant one and go to BUSY. Latch the requester's addr, wr and wdata into the mem_* registers, record the owner, and load cnt = MEM_LAT. Fetch grants force mem_wr = 0.
- Default priority: d_req beats if_req, because the data access belongs to the older instruction.
- BUSY: mem_en is high in the first BUSY cycle only. cnt decrements each cycle. In the cycle with cnt == 1, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: assert the owner's ready for exactly one cycle, then go to IDLE. Requests seen in DONE are not granted.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after a ready pulse is a new transaction.
- Requester inputs may change after the grant. The latched copies drive memory.
- For stores, d_rdata holds its previous value. d_ready still pulses.
- Memory contract: mem_rdata is valid in the MEM_LAT-th cycle counting the mem_en cycle as 1. With MEM_LAT = 1 the read is combinational in the mem_en cycle.
- A request dropped while the arbiter is BUSY on its behalf still completes. Its ready pulse is produced and ignored.
- Reset mid-transaction: return to IDLE immediately. All outputs are cleared and the transaction is abandoned. A write already strobed may have completed in memory.

## Timing
- Reset values: state = IDLE, mem_en = mem_wr = 0, mem_addr = mem_wdata = 0, if_rdata = d_rdata = 0, if_ready = d_ready = 0, cnt = 0. stall_* follow their combinational definitions.
- Request high in IDLE at cycle 0:
  - mem_en high in cycle 1;
  - data captured at the end of cycle MEM_LAT;
  - ready high in cycle MEM_LAT+1;
  - earliest next grant decision in cycle MEM_LAT+2.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- mem_en, mem_wr, mem_addr, mem_wdata, *_rdata and *_ready are registered outputs. stall_if and stall_d are combinational.
- Simultaneous if_req and d_req in IDLE: only one is granted. The loser stays stalled and is granted at the next IDLE.

## Configuration
- MEMARB_RR_EN defined: round-robin between the two ports.
  - A last_grant register (reset value = fetch) is updated at each grant.
  - When both ports request in IDLE, the port not granted last time wins.
  - A single requester always wins regardless of last_grant.
- MEMARB_RR_EN undefined: fixed data-over-fetch priority and no last_grant register.

## Test plan
- Reset, MEM_LAT=4, single fetch: if_req=1, if_addr=0x0010, memory returns 0xA5C3. Required: mem_en only in cycle 1 with mem_wr=0 and mem_addr=0x0010; if_ready only in cycle 5 with if_rdata=0xA5C3; stall_if high in cycles 0-4.
- Store then load: d_wr=1, d_addr=0x0100, d_wdata=0xBEEF, then d_wr=0 to the same address. Required: mem_wr=1 with mem_wdata=0xBEEF at the first issue; the load returns d_rdata=0xBEEF; the two d_ready pulses are 6 cycles apart.
- Contention, macro off: if_req and d_req rise together. Required: data granted first (d_ready in cycle 5), fetch granted in cycle 6 (if_ready in cycle 11); repeat with both requests held continuously, and fetch must wait for every data request to finish.
- Contention, MEMARB_RR_EN on: both ports held high for 4 transactions. Required: grant order data, fetch, data, fetch.
- Reset in cycle 2 of a load. Required: all outputs return to 0 asynchronously and no d_ready pulse follows; a new request after rst drops completes normally.
- MEM_LAT=1 corner case: single load. Required: mem_en in cycle 1, capture in cycle 1, d_ready in cycle 2, next grant in cycle 3.
